spi_slave_8_lane: RTL and testbench



---
 rtl/spi_slave_8_lane.sv | 98 +++++++++
 tb/tb_spi_slave_8_lane.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_8_lane.sv
// rtl/spi_slave_8_lane.sv - receive-only 8-lane SPI slave assembling NUM_BYTES bytes into one word.
// Optional: define SPI_SLAVE_IRQ_LATCH_EN to make irq_rx a level held until the next CS falling edge.
module spi_slave_8_lane #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_BYTES   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     spi_clk_in,
   input  logic [7:0]               spi_data_in,
   input  logic                     spi_cs_n_in,
   output logic [8*NUM_BYTES-1:0]   rx_data,
   output logic                     rx_valid,
   output logic                     rx_busy,
   output logic                     irq_rx
);

   localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

   logic [SYNC_STAGES-1:0]  clk_sync;
   logic [SYNC_STAGES-1:0]  cs_sync;
   logic [7:0]              data_sync [SYNC_STAGES];
   logic                    clk_prev;
   logic [CW-1:0]           cnt;
   logic [8*NUM_BYTES-1:0]  buffer;
   logic                    done;

   logic       clk_s;
   logic       cs_n_s;
   logic [7:0] data_s;
   logic       rise;

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign cs_n_s = cs_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];
   assign rise   = clk_s & ~clk_prev;

   // Data travels through the same depth as spi_clk, so data_s is the byte set up for this rise.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync <= '0;
         cs_sync  <= '1;
         for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
         clk_prev <= 1'b0;
         cnt      <= '0;
         buffer   <= '0;
         done     <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_busy  <= 1'b0;
      end else begin
         clk_sync     <= {clk_sync[SYNC_STAGES-2:0], spi_clk_in};
         cs_sync      <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_in};
         data_sync[0] <= spi_data_in;
         for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
         clk_prev <= clk_s;
         rx_busy  <= ~cs_n_s;
         rx_valid <= done;
         done     <= 1'b0;
         if (done) rx_data <= buffer;
         // A pending completion is independent of CS, so a word finished just before deselect still lands.
         if (cs_n_s) begin
            cnt <= '0;
         end else if (rise) begin
            buffer[{cnt, 3'b000} +: 8] <= data_s;
            if (cnt == LAST) begin
               cnt  <= '0;
               done <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

`ifdef SPI_SLAVE_IRQ_LATCH_EN
   logic cs_prev;

   // Set has priority over the clear from a new transfer starting.
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_prev <= 1'b1;
         irq_rx  <= 1'b0;
      end else begin
         cs_prev <= cs_n_s;
         if (done) irq_rx <= 1'b1;
         else if (cs_prev & ~cs_n_s) irq_rx <= 1'b0;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) irq_rx <= 1'b0;
      else       irq_rx <= done;
   end
`endif

endmodule

// File: tb/tb_spi_slave_8_lane.sv
// tb/tb_spi_slave_8_lane.sv - directed bench for spi_slave_8_lane.
module tb_spi_slave_8_lane;

   logic         clk;
   logic         reset;
   logic         spi_clk_in;
   logic [7:0]   spi_data_in;
   logic         spi_cs_n_in;
   logic [127:0] rx_data;
   logic         rx_valid;
   logic         rx_busy;
   logic         irq_rx;

   spi_slave_8_lane #(.SYNC_STAGES(2), .NUM_BYTES(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .spi_clk_in  (spi_clk_in),
      .spi_data_in (spi_data_in),
      .spi_cs_n_in (spi_cs_n_in),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_busy     (rx_busy),
      .irq_rx      (irq_rx)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   localparam logic [127:0] EXP1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] EXP2  = 128'hbbc4e0d86a7b0430d8cdb78070b4c5aa;
   localparam logic [127:0] EXP_A = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] EXP_B = 128'h1f1e1d1c1b1a19181716151413121110;

   int           passed = 0;
   int           total  = 0;
   int           valid_cnt = 0;
   int           irq_mismatch = 0;
   int           base;
   logic [127:0] words [$];
   logic [7:0]   tx [32];
   logic [7:0]   t1 [16] = '{8'h5a, 8'hc5, 8'hb4, 8'h70, 8'h80, 8'hb7, 8'hcd, 8'hd8,
                             8'h30, 8'h04, 8'h7b, 8'h6a, 8'hd8, 8'he0, 8'hc4, 8'h69};
   time          t_rise = 0;
   time          last_lat = 0;

   always @(negedge clk) begin
      if (rx_valid) begin
         valid_cnt++;
         words.push_back(rx_data);
         last_lat = $time - t_rise;
      end
`ifndef SPI_SLAVE_IRQ_LATCH_EN
      if (irq_rx !== rx_valid) irq_mismatch++;
`endif
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // 20 setup + 40 high + 20 after fall: 40-unit low phase across consecutive bytes.
   task automatic send_byte(input logic [7:0] b);
      spi_data_in = b;
      #20;
      spi_clk_in = 1'b1;
      t_rise = $time;
      #40;
      spi_clk_in = 1'b0;
      #20;
   endtask

   task automatic xfer(input int n);
      spi_cs_n_in = 1'b0;
      #40;
      for (int i = 0; i < n; i++) send_byte(tx[i]);
      #40;
      spi_cs_n_in = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic load_t1();
      for (int i = 0; i < 16; i++) tx[i] = t1[i];
   endtask

   initial begin
      reset       = 1'b1;
      spi_clk_in  = 1'b0;
      spi_data_in = 8'h00;
      spi_cs_n_in = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_rx_data", rx_data, 128'h0);
      check("reset_rx_valid", {127'h0, rx_valid}, 128'h0);
      check("reset_rx_busy", {127'h0, rx_busy}, 128'h0);
      check("reset_irq_rx", {127'h0, irq_rx}, 128'h0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Transfer 1, with busy sampled mid-transfer
      load_t1();
      spi_cs_n_in = 1'b0;
      repeat (4) @(negedge clk);
      check("t1_busy_during", {127'h0, rx_busy}, 128'h1);
      for (int i = 0; i < 16; i++) send_byte(tx[i]);
      #40;
      spi_cs_n_in = 1'b1;
      repeat (10) @(negedge clk);
      check("t1_valid_count", 128'(valid_cnt), 128'd1);
      check("t1_word", words[0], EXP1);
      check("t1_rx_data", rx_data, EXP1);
      check("t1_busy_after", {127'h0, rx_busy}, 128'h0);
      check("t1_latency_ok", {127'h0, (last_lat >= 60 && last_lat <= 100)}, 128'h1);
`ifdef SPI_SLAVE_IRQ_LATCH_EN
      check("t1_irq_held", {127'h0, irq_rx}, 128'h1);
`else
      check("t1_irq_low", {127'h0, irq_rx}, 128'h0);
`endif

      // Transfer 2: first and last bytes changed
      tx[0]  = 8'haa;
      tx[15] = 8'hbb;
      base = valid_cnt;
`ifdef SPI_SLAVE_IRQ_LATCH_EN
      spi_cs_n_in = 1'b0;
      repeat (5) @(negedge clk);
      check("t2_irq_cleared", {127'h0, irq_rx}, 128'h0);
`endif
      xfer(16);
      check("t2_valid_count", 128'(valid_cnt - base), 128'd1);
      check("t2_low_byte", {120'h0, rx_data[7:0]}, 128'haa);
      check("t2_high_byte", {120'h0, rx_data[127:120]}, 128'hbb);
      check("t2_rx_data", rx_data, EXP2);

      // Abort after 4 bytes, then a clean word
      tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44;
      base = valid_cnt;
      xfer(4);
      check("abort_no_valid", 128'(valid_cnt - base), 128'd0);
      check("abort_rx_data", rx_data, EXP2);
      load_t1();
      base = valid_cnt;
      xfer(16);
      check("post_abort_valid", 128'(valid_cnt - base), 128'd1);
      check("post_abort_rx_data", rx_data, EXP1);

      // 32 bytes under one chip select
      for (int i = 0; i < 32; i++) tx[i] = 8'(i);
      base = valid_cnt;
      xfer(32);
      check("b32_valid_count", 128'(valid_cnt - base), 128'd2);
      check("b32_word0", words[base], EXP_A);
      check("b32_word1", words[base+1], EXP_B);

      // Reset mid-transfer after 8 bytes
      load_t1();
      spi_cs_n_in = 1'b0;
      #40;
      for (int i = 0; i < 8; i++) send_byte(tx[i]);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_rx_data", rx_data, 128'h0);
      check("midrst_rx_valid", {127'h0, rx_valid}, 128'h0);
      check("midrst_rx_busy", {127'h0, rx_busy}, 128'h0);
      check("midrst_irq_rx", {127'h0, irq_rx}, 128'h0);
      spi_cs_n_in = 1'b1;
      reset = 1'b0;
      repeat (6) @(negedge clk);
      base = valid_cnt;
      xfer(16);
      check("post_rst_valid", 128'(valid_cnt - base), 128'd1);
      check("post_rst_rx_data", rx_data, EXP1);

`ifndef SPI_SLAVE_IRQ_LATCH_EN
      check("irq_matches_valid", 128'(irq_mismatch), 128'd0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
